// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM and the ALU decoder.
// States ADDIEX/ADDIWB exist only when MULTICYCLE_ADDI_EN is defined.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // aluop is expanded further by the ALU decoder using funct
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH  = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_EXEC    = 4'd7,
        S_RWB     = 4'd8,
        S_BRANCH  = 4'd9,
        S_JUMP    = 4'd10,
`ifdef MULTICYCLE_ADDI_EN
        S_ILLEGAL = 4'd11,
        S_ADDIEX  = 4'd12,
        S_ADDIWB  = 4'd13
`else
        S_ILLEGAL = 4'd11
`endif
    } state_t;

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: registered state plus
// combinational output decode. Define MULTICYCLE_ADDI_EN to support addi.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               pcwrite,
    output logic               pcwritecond,
    output logic               iord,
    output logic               memread,
    output logic               memwrite,
    output logic               irwrite,
    output logic               memtoreg,
    output logic               regdst,
    output logic               regwrite,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsource,
    output logic [1:0]         aluop,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state
);

    state_t     cur;
    logic [5:0] op_q;

    assign state = STATE_W'(cur);

    // DECODE branches on the live opcode; everything after uses the latched op_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur  <= S_RESET;
            op_q <= '0;
        end else begin
            case (cur)
                S_RESET:  cur <= S_FETCH;
                S_FETCH:  if (mem_ready) cur <= S_DECODE;
                S_DECODE: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_RTYPE:     cur <= S_EXEC;
                        OP_LW, OP_SW: cur <= S_MEMADR;
                        OP_BEQ:       cur <= S_BRANCH;
                        OP_J:         cur <= S_JUMP;
`ifdef MULTICYCLE_ADDI_EN
                        OP_ADDI:      cur <= S_ADDIEX;
`endif
                        default:      cur <= S_ILLEGAL;
                    endcase
                end
                S_MEMADR: cur <= (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD:  if (mem_ready) cur <= S_MEMWB;
                S_MEMWR:  if (mem_ready) cur <= S_FETCH;
                S_EXEC:   cur <= S_RWB;
`ifdef MULTICYCLE_ADDI_EN
                S_ADDIEX: cur <= S_ADDIWB;
`endif
                default:  cur <= S_FETCH;
            endcase
        end
    end

    always_comb begin
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdst      = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = SRCB_RT;
        pcsource    = PCSRC_ALU;
        aluop       = ALUOP_ADD;
        illegal_op  = 1'b0;
        case (cur)
            S_FETCH: begin
                memread = 1'b1;
                alusrcb = SRCB_FOUR;
                irwrite = mem_ready;
                pcwrite = mem_ready;
            end
            S_DECODE: alusrcb = SRCB_IMMSH;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            S_MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
            end
            S_EXEC: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            S_RWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            S_BRANCH: begin
                alusrca     = 1'b1;
                aluop       = ALUOP_SUB;
                pcwritecond = 1'b1;
                pcsource    = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                pcwrite  = 1'b1;
                pcsource = PCSRC_JUMP;
            end
            S_ILLEGAL: illegal_op = 1'b1;
`ifdef MULTICYCLE_ADDI_EN
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            S_ADDIWB: regwrite = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares state plus all outputs.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'b0;
    logic       mem_ready = 1'b0;
    logic       pcwrite, pcwritecond, iord, memread, memwrite, irwrite;
    logic       memtoreg, regdst, regwrite, alusrca, illegal_op;
    logic [1:0] alusrcb, pcsource, aluop;
    logic [3:0] state;

    int tests = 0;
    int fails = 0;

    multicycle_control #(.STATE_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord),
        .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .memtoreg(memtoreg), .regdst(regdst), .regwrite(regwrite),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsource(pcsource),
        .aluop(aluop), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    // Output vector order: pcwrite pcwritecond iord memread memwrite irwrite
    // memtoreg regdst regwrite alusrca alusrcb pcsource aluop illegal_op
    logic [16:0] outs;
    assign outs = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite,
                   memtoreg, regdst, regwrite, alusrca, alusrcb, pcsource,
                   aluop, illegal_op};

    localparam logic [16:0] E_ZERO   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_FETCHW = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] E_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] E_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] E_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] E_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_00_10_0;
    localparam logic [16:0] E_RWB    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] E_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] E_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_10_00_0;
    localparam logic [16:0] E_ILL    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;
`ifdef MULTICYCLE_ADDI_EN
    localparam logic [16:0] E_ADDIEX = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] E_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
`endif

    typedef struct {
        string       name;
        logic [3:0]  st;
        logic [16:0] o;
    } exp_t;

    exp_t sbq[$];

    task automatic checkOutput(input string name, input logic [20:0] act,
                               input logic [20:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got state=%0d outs=%b, expected state=%0d outs=%b",
                     name, act[20:17], act[16:0], exp[20:17], exp[16:0]);
        end
    endtask

    task automatic pushExp(input string name, input state_t st, input logic [16:0] o);
        exp_t e;
        e.name = name;
        e.st   = st;
        e.o    = o;
        sbq.push_back(e);
    endtask

    // One cycle: after the edge, drive inputs and queue the expected response
    task automatic applyStimulus(input string name, input logic [5:0] op,
                                 input logic mr, input state_t st,
                                 input logic [16:0] o);
        @(posedge clk);
        #1;
        opcode    = op;
        mem_ready = mr;
        pushExp(name, st, o);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checkOutput(e.name, {state, outs}, {e.st, e.o});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset held across an edge, then released
        @(posedge clk); #2; pushExp("reset_hold", S_RESET, E_ZERO);
        @(posedge clk); #2; rst_n = 1'b1; pushExp("reset_rel", S_RESET, E_ZERO);

        // lw, zero wait
        applyStimulus("lw_fetch",  6'b000000, 1'b1, S_FETCH,  E_FETCH);
        applyStimulus("lw_decode", OP_LW,     1'b0, S_DECODE, E_DECODE);
        applyStimulus("lw_memadr", 6'b111000, 1'b0, S_MEMADR, E_MEMADR);
        applyStimulus("lw_memrd",  6'b111000, 1'b1, S_MEMRD,  E_MEMRD);
        applyStimulus("lw_memwb",  6'b111000, 1'b0, S_MEMWB,  E_MEMWB);

        // sw with three wait cycles
        applyStimulus("sw_fetch",  6'b000000, 1'b1, S_FETCH,  E_FETCH);
        applyStimulus("sw_decode", OP_SW,     1'b1, S_DECODE, E_DECODE);
        applyStimulus("sw_memadr", OP_LW,     1'b1, S_MEMADR, E_MEMADR);
        applyStimulus("sw_wait1",  OP_LW,     1'b0, S_MEMWR,  E_MEMWR);
        applyStimulus("sw_wait2",  OP_LW,     1'b0, S_MEMWR,  E_MEMWR);
        applyStimulus("sw_wait3",  OP_LW,     1'b0, S_MEMWR,  E_MEMWR);
        applyStimulus("sw_done",   OP_LW,     1'b1, S_MEMWR,  E_MEMWR);

        // R-type; opcode changes after DECODE must not alter the path
        applyStimulus("r_fetch",   6'b000000, 1'b1, S_FETCH,  E_FETCH);
        applyStimulus("r_decode",  OP_RTYPE,  1'b0, S_DECODE, E_DECODE);
        applyStimulus("r_exec",    OP_LW,     1'b1, S_EXEC,   E_EXEC);
        applyStimulus("r_rwb",     OP_BEQ,    1'b1, S_RWB,    E_RWB);

        // beq then j
        applyStimulus("beq_fetch", 6'b000000, 1'b1, S_FETCH,  E_FETCH);
        applyStimulus("beq_dec",   OP_BEQ,    1'b1, S_DECODE, E_DECODE);
        applyStimulus("beq_br",    6'b000000, 1'b1, S_BRANCH, E_BRANCH);
        applyStimulus("j_fetch",   6'b000000, 1'b1, S_FETCH,  E_FETCH);
        applyStimulus("j_dec",     OP_J,      1'b1, S_DECODE, E_DECODE);
        applyStimulus("j_jump",    6'b000000, 1'b0, S_JUMP,   E_JUMP);

        // Fetch stall, illegal opcode, then addi
        applyStimulus("ill_fwait", 6'b000000, 1'b0, S_FETCH,   E_FETCHW);
        applyStimulus("ill_fetch", 6'b000000, 1'b1, S_FETCH,   E_FETCH);
        applyStimulus("ill_dec",   6'b111111, 1'b1, S_DECODE,  E_DECODE);
        applyStimulus("ill_pulse", 6'b000000, 1'b1, S_ILLEGAL, E_ILL);
        applyStimulus("addi_fet",  6'b000000, 1'b1, S_FETCH,   E_FETCH);
        applyStimulus("addi_dec",  OP_ADDI,   1'b1, S_DECODE,  E_DECODE);
`ifdef MULTICYCLE_ADDI_EN
        applyStimulus("addi_ex",   6'b000000, 1'b1, S_ADDIEX,  E_ADDIEX);
        applyStimulus("addi_wb",   6'b000000, 1'b1, S_ADDIWB,  E_ADDIWB);
`else
        applyStimulus("addi_ill",  6'b000000, 1'b1, S_ILLEGAL, E_ILL);
`endif

        // sw stalled in MEMWR, then reset asserted mid-instruction
        applyStimulus("rst_fetch", 6'b000000, 1'b1, S_FETCH,  E_FETCH);
        applyStimulus("rst_dec",   OP_SW,     1'b1, S_DECODE, E_DECODE);
        applyStimulus("rst_adr",   6'b000000, 1'b0, S_MEMADR, E_MEMADR);
        applyStimulus("rst_memwr", 6'b000000, 1'b0, S_MEMWR,  E_MEMWR);
        @(posedge clk); #1;
        checkOutput("pre_rst_memwr", {state, outs}, {S_MEMWR, E_MEMWR});
        #1; rst_n = 1'b0; #1;
        checkOutput("async_memwrite", {17'b0, memwrite, state}, {17'b0, 1'b0, S_RESET});
        pushExp("rst_mid", S_RESET, E_ZERO);
        @(posedge clk); #2; rst_n = 1'b1; pushExp("rst_mid_rel", S_RESET, E_ZERO);
        applyStimulus("rst_refetch", 6'b000000, 1'b0, S_FETCH, E_FETCHW);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        tests++;
        if (sbq.size() != 0) begin
            fails++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
